// File: rtl/register_pkg.sv
// Shared definitions for bus-attached data registers.
package register_pkg;

   // Default storage and bus width of a data register.
   localparam int DATA_WIDTH = 8;

   // Storage contents after reset. Zero-extended to the instance width.
   localparam int RESET_VALUE = 0;

   // Bus output enable. The register drives only for a plain read outside reset.
   // A write in the same cycle keeps the bus released so the external writer is
   // never fought.
   function automatic logic bus_oe(input logic re, input logic we, input logic rst);
      return re & ~we & ~rst;
   endfunction

endpackage

// File: rtl/register_tristate_driver.sv
// Tri-state output stage. Drives data_in onto a shared bus while oe is high
// and leaves the bus floating otherwise.
module tristate_driver #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] data_in,
   input  logic             oe,
   inout  wire  [WIDTH-1:0] bus
);

   // Drive or release every bus bit together.
   assign bus = oe ? data_in : {WIDTH{1'bz}};

endmodule

// File: rtl/register.sv
// General-purpose data register on the shared bidirectional data bus.
// Captures the bus on a rising edge when write-enabled and drives its stored
// value back onto the bus when read-enabled.
module register
   import register_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             re,
   input  logic             we,
   input  logic             Q,
   inout  wire  [WIDTH-1:0] data_bus
);

   localparam logic [WIDTH-1:0] RESET_BITS = WIDTH'(RESET_VALUE);

   logic [WIDTH-1:0] value_r;
   logic             oe_s;
   logic             unused_q_s;

   // Q is a reserved qualifier with no effect on storage or the bus.
   assign unused_q_s = Q;

   // Read path is combinational so the bus follows re within the same cycle.
   assign oe_s = bus_oe(re, we, rst);

   // Storage flop: async clear, otherwise capture the bus when write-enabled.
   // Whatever is on the bus (including X or Z) is stored unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_r <= RESET_BITS;
      end else if (we) begin
         value_r <= data_bus;
      end else begin
         value_r <= value_r;
      end
   end

   tristate_driver #(
      .WIDTH (WIDTH)
   ) u_drv (
      .data_in (value_r),
      .oe      (oe_s),
      .bus     (data_bus)
   );

endmodule

// File: tb/tb_register.sv
// Directed testbench for the bus-attached data register.
module tb_register;

   logic       clk;
   logic       rst;
   logic       re;
   logic       we;
   logic       q;
   logic       tb_en;
   logic [7:0] tb_data;
   wire  [7:0] data_bus;

   int tests_run;
   int tests_failed;

   assign data_bus = tb_en ? tb_data : 8'bzzzz_zzzz;

   register #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .re       (re),
      .we       (we),
      .Q        (q),
      .data_bus (data_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench drives a value with we for one edge, then releases bus and we.
   task automatic bus_write(input logic [7:0] d);
      @(negedge clk);
      re = 1'b0; we = 1'b1; tb_en = 1'b1; tb_data = d;
      @(negedge clk);
      we = 1'b0; tb_en = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; re = 1'b1; we = 1'b0; tb_en = 1'b0;
      #1;
      tests_run++;
      if (dut.oe_s !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_bus_release: oe=%b want 0", dut.oe_s);
      end
      @(negedge clk);
      tests_run++;
      if (dut.value_r !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_value: got %h want 00", dut.value_r);
      end
      rst = 1'b0;
      #1;
      tests_run++;
      if (dut.oe_s !== 1'b1 || data_bus !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_read: oe=%b bus=%h want oe=1 bus=00", dut.oe_s, data_bus);
      end
      re = 1'b0;
   endtask

   task automatic test_write_idle();
      int floats;
      bus_write(8'hA5);
      floats = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (dut.oe_s !== 1'b0) floats++;
      end
      tests_run++;
      if (floats != 0) begin
         tests_failed++;
         $display("FAIL idle_float: %0d driven cycles want 0", floats);
      end
      re = 1'b1;
      #1;
      tests_run++;
      if (data_bus !== 8'hA5) begin
         tests_failed++;
         $display("FAIL write_idle_read: got %h want a5", data_bus);
      end
      @(negedge clk);
      tests_run++;
      if (data_bus !== 8'hA5 || dut.value_r !== 8'hA5) begin
         tests_failed++;
         $display("FAIL nondestructive_read: bus=%h value=%h want a5", data_bus, dut.value_r);
      end
      re = 1'b0;
   endtask

   task automatic test_overwrite();
      bus_write(8'h3C);
      repeat (10) @(negedge clk);
      re = 1'b1;
      #1;
      tests_run++;
      if (data_bus !== 8'h3C) begin
         tests_failed++;
         $display("FAIL overwrite_read: got %h want 3c", data_bus);
      end
      re = 1'b0;
   endtask

   task automatic test_simultaneous();
      @(negedge clk);
      re = 1'b1; we = 1'b1; tb_en = 1'b1; tb_data = 8'h5A;
      #1;
      tests_run++;
      if (dut.oe_s !== 1'b0 || data_bus !== 8'h5A) begin
         tests_failed++;
         $display("FAIL rw_no_contention: oe=%b bus=%h want oe=0 bus=5a", dut.oe_s, data_bus);
      end
      @(negedge clk);
      we = 1'b0; tb_en = 1'b0;
      #1;
      tests_run++;
      if (dut.oe_s !== 1'b1 || data_bus !== 8'h5A) begin
         tests_failed++;
         $display("FAIL rw_next_read: oe=%b bus=%h want oe=1 bus=5a", dut.oe_s, data_bus);
      end
      re = 1'b0;
   endtask

   task automatic test_async_reset();
      bus_write(8'hFF);
      tests_run++;
      if (dut.value_r !== 8'hFF) begin
         tests_failed++;
         $display("FAIL async_pre_store: got %h want ff", dut.value_r);
      end
      re = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      tests_run++;
      if (dut.value_r !== 8'h00 || dut.oe_s !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_clear: value=%h oe=%b want 00 0", dut.value_r, dut.oe_s);
      end
      #1;
      rst = 1'b0;
      #1;
      tests_run++;
      if (data_bus !== 8'h00) begin
         tests_failed++;
         $display("FAIL async_after_read: got %h want 00", data_bus);
      end
      // Write attempted while reset is held across the edge is discarded.
      @(negedge clk);
      re = 1'b0; rst = 1'b1; we = 1'b1; tb_en = 1'b1; tb_data = 8'h77;
      @(negedge clk);
      we = 1'b0; tb_en = 1'b0; rst = 1'b0;
      tests_run++;
      if (dut.value_r !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_mid_write: got %h want 00", dut.value_r);
      end
   endtask

   task automatic test_q_ignored();
      int bad;
      q = 1'bx;
      bus_write(8'h81);
      bad = 0;
      re = 1'b1;
      for (int i = 0; i < 4; i++) begin
         q = i[0];
         #1;
         if (data_bus !== 8'h81) bad++;
         @(negedge clk);
      end
      q = 1'bz;
      #1;
      if (data_bus !== 8'h81) bad++;
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL q_ignored: %0d bad reads want 0 (value=%h)", bad, dut.value_r);
      end
      re = 1'b0; q = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] vec [3];
      int bad;
      vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'hC3;
      bad = 0;
      @(negedge clk);
      we = 1'b1; tb_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tb_data = vec[i];
         @(negedge clk);
         if (dut.value_r !== vec[i]) bad++;
      end
      we = 1'b0; tb_en = 1'b0; re = 1'b1;
      #1;
      tests_run++;
      if (bad != 0 || data_bus !== 8'hC3) begin
         tests_failed++;
         $display("FAIL back_to_back: %0d bad writes bus=%h want 0 c3", bad, data_bus);
      end
      @(negedge clk);
      re = 1'b0;
      #1;
      tests_run++;
      if (dut.oe_s !== 1'b0) begin
         tests_failed++;
         $display("FAIL re_release: oe=%b want 0", dut.oe_s);
      end
   endtask

   initial begin
      tests_run = 0; tests_failed = 0;
      rst = 1'b1; re = 1'b0; we = 1'b0; q = 1'b0; tb_en = 1'b0; tb_data = 8'h00;
      test_reset();
      test_write_idle();
      test_overwrite();
      test_simultaneous();
      test_async_reset();
      test_q_ignored();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
